multicycle_execute_unit: RTL and testbench
==========================================

// Module: multicycle_execute_unit
// PURPOSE
//  Parametrised execute stage between decode and writeback. Valid/ready handshake on both sides.
//  Single-cycle ALU/shift/LOADC/memory ops plus an iterative DATA_W-cycle MUL.
//  Combinational forwarding result for the dependency unit; sticky halt.
// PARAMETERS
//  DATA_W   16  operand/result width (>=8, power of two)
//  ADDR_W   10  data-memory address width (<= DATA_W)
//  GPR_W     3  register-index width
//  CONST_W   8  LOADC constant width (< DATA_W)
// PORTS
//  clock            in   1           clock, rising edge
//  reset            in   1           asynchronous, active-low
//  in_valid         in   1           decode presents an op
//  in_ready         out  1           stage accepts op this cycle
//  op               in   4           EX_* opcode (architecture.vh)
//  dst              in   GPR_W       destination register index
//  opa, opb         in   DATA_W      source operands (STORE: opa=addr, opb=data)
//  shamt            in   $clog2(DATA_W)  shift amount
//  constant         in   CONST_W     LOADC immediate
//  dep_valid        out  1           dep_result/dep_destination meaningful
//  dep_result       out  DATA_W      forwarded result (comb.)
//  dep_destination  out  GPR_W       forwarded destination (comb.)
//  mem_read         out  1           load strobe, accept cycle only
//  mem_write        out  1           store strobe, accept cycle only
//  address          out  ADDR_W      memory address
//  data_out         out  DATA_W      store data
//  out_valid        out  1           registered result valid
//  out_ready        in   1           writeback consumes
//  result           out  DATA_W      registered result
//  destination      out  GPR_W       registered destination
//  writeback        out  2           WB_NONE/WB_REGISTER/WB_MEMORY
//  halt             out  1           sticky halt
// BEHAVIOUR
//  - Reset: state IDLE; result, destination, writeback, out_valid, halt, mul regs = 0.
//    Reset mid-MUL abandons the multiply; no output follows.
//  - Accept = in_valid & in_ready; in_ready = (state==IDLE) & !halt & (!out_valid | out_ready).
//  - FSM IDLE->IDLE on single-cycle accept; IDLE->MUL on MUL accept; MUL->IDLE after DATA_W
//    iterations, result loaded same edge. Latency: single-cycle 1 clk, MUL DATA_W+1 clk.
//  - ADD/SUB/AND/OR/XOR/NAND/NOR/XNOR on opa,opb mod 2^DATA_W. SHL/SHR logical, SHRA
//    arithmetic (sign of opa); shamt 0 passes opa. LOADC: {opa[DATA_W-1:CONST_W],constant}.
//  - MUL: shift-add, low DATA_W bits of product; operands latched at accept.
//  - LOAD: mem_read=1, address=opa[ADDR_W-1:0], writeback=WB_MEMORY, result=0.
//  - STORE: mem_write=1, address=opa, data_out=opb, writeback=WB_NONE.
//  - ALU/shift/LOADC/MUL: writeback=WB_REGISTER. Strobes never assert without accept.
//  - address/data_out are 0 when no strobe (no latches; all comb. paths fully assigned).
//  - dep_valid=1 in accept cycle of any WB_REGISTER single-cycle op and in the final MUL
//    iteration cycle; else 0 and dep_result/dep_destination = 0.
//  - Output reg holds while out_valid & !out_ready; cleared on consume without new accept.
//    Accept and consume same cycle: new value loaded, out_valid stays 1.
//  - HALT accept: halt=1 next cycle, writeback=WB_NONE, stays until reset; in_ready=0 after.
//  - Undefined op codes: treated as NOP (WB_NONE, out_valid pulses).
// CONFIGURATION
//  EXEC_FLAGS_EN defined: extra output flags[3:0]={Z,N,C,V}, registered with result on
//   every WB_REGISTER op; C/V from ADD/SUB only, cleared otherwise; reset 0.
//  Undefined: no flags port, no flag logic.
// STRUCTURE
//  architecture.vh: EX_* opcode constants, WB_* codes, FSM state encodings.
//  Sub-module shift_add_multiplier (start, a, b -> busy, done, product) holds the MUL iteration.
// TESTING
//  1 ADD opa=16'h7FFF opb=1, dst=2 -> dep_result 16'h8000 same cycle; result next clk, WB_REGISTER.
//  2 MUL 123*45 -> in_ready=0 for 16 clks, result 16'd5535 at clk 17; 300*300 -> 16'h5F90.
//  3 out_ready=0 for 3 clks after ADD -> result held, in_ready=0; release -> next op accepted.
//  4 STORE opa=16'h0123 opb=16'hBEEF -> mem_write 1 clk, address 10'h123, data_out BEEF, WB_NONE.
//  5 SHRA 16'h8000 by 15 -> 16'hFFFF; SHR -> 16'h0001; LOADC opa=16'hAB00 c=8'h5C -> 16'hAB5C.
//  6 reset low at MUL iter 5 -> all outputs 0, out_valid never rises; HALT -> halt sticky, in_ready 0.

Source files
------------

// File: rtl/multicycle_execute_unit_pkg.sv
// Shared opcode, writeback and FSM state encodings for the execute stage.
package multicycle_execute_unit_pkg;

  typedef enum logic [3:0] {
    EX_ADD   = 4'd0,
    EX_SUB   = 4'd1,
    EX_AND   = 4'd2,
    EX_OR    = 4'd3,
    EX_XOR   = 4'd4,
    EX_NAND  = 4'd5,
    EX_NOR   = 4'd6,
    EX_XNOR  = 4'd7,
    EX_SHL   = 4'd8,
    EX_SHR   = 4'd9,
    EX_SHRA  = 4'd10,
    EX_LOADC = 4'd11,
    EX_MUL   = 4'd12,
    EX_LOAD  = 4'd13,
    EX_STORE = 4'd14,
    EX_HALT  = 4'd15
  } ex_op_e;

  typedef enum logic [1:0] {
    WB_NONE     = 2'd0,
    WB_REGISTER = 2'd1,
    WB_MEMORY   = 2'd2
  } wb_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/shift_add_multiplier.sv
// Iterative shift-add multiplier: DATA_W busy cycles after start, low DATA_W product bits.
// done is asserted combinationally in the final iteration with product already valid.
module shift_add_multiplier #(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);
  localparam int CNT_W = $clog2(DATA_W);

  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_next;

  // Product includes the current iteration's partial so the top can forward it early.
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign busy     = busy_q;
  assign done     = busy_q & (cnt_q == CNT_W'(DATA_W - 1));
  assign product  = acc_next;

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = b;
    end else if (busy_q) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/multicycle_execute_unit.sv
// Execute stage: single-cycle ALU/shift/LOADC/memory ops, iterative MUL, comb. forwarding, sticky halt.
// Defining EXEC_FLAGS_EN adds a registered flags[3:0] = {Z,N,C,V} output.
module multicycle_execute_unit
  import multicycle_execute_unit_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 10,
  parameter int GPR_W   = 3,
  parameter int CONST_W = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                op,
  input  logic [GPR_W-1:0]          dst,
  input  logic [DATA_W-1:0]         opa,
  input  logic [DATA_W-1:0]         opb,
  input  logic [$clog2(DATA_W)-1:0] shamt,
  input  logic [CONST_W-1:0]        constant,
  output logic                      dep_valid,
  output logic [DATA_W-1:0]         dep_result,
  output logic [GPR_W-1:0]          dep_destination,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [ADDR_W-1:0]         address,
  output logic [DATA_W-1:0]         data_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         result,
  output logic [GPR_W-1:0]          destination,
  output logic [1:0]                writeback,
  output logic                      halt
`ifdef EXEC_FLAGS_EN
  ,
  output logic [3:0]                flags
`endif
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [GPR_W-1:0]  destination_q, destination_d;
  logic [1:0]        writeback_q, writeback_d;
  logic              out_valid_q, out_valid_d;
  logic              halt_q, halt_d;
  logic [GPR_W-1:0]  mul_dst_q, mul_dst_d;

  logic              accept, mul_start, single_reg, load_out;
  logic              mul_busy, mul_done;
  logic [DATA_W-1:0] mul_product;
  logic [DATA_W-1:0] alu_res;
  logic [1:0]        alu_wb;

  assign in_ready   = (state_q == ST_IDLE) & !mul_busy & !halt_q & (!out_valid_q | out_ready);
  assign accept     = in_valid & in_ready;
  assign mul_start  = accept & (op == EX_MUL);
  assign single_reg = accept & (op != EX_MUL) & (alu_wb == WB_REGISTER);
  assign load_out   = (accept & (op != EX_MUL)) | mul_done;

  shift_add_multiplier #(.DATA_W(DATA_W)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .a       (opa),
    .b       (opb),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    alu_res = '0;
    alu_wb  = WB_REGISTER;
    case (op)
      EX_ADD:   alu_res = opa + opb;
      EX_SUB:   alu_res = opa - opb;
      EX_AND:   alu_res = opa & opb;
      EX_OR:    alu_res = opa | opb;
      EX_XOR:   alu_res = opa ^ opb;
      EX_NAND:  alu_res = ~(opa & opb);
      EX_NOR:   alu_res = ~(opa | opb);
      EX_XNOR:  alu_res = ~(opa ^ opb);
      EX_SHL:   alu_res = opa << shamt;
      EX_SHR:   alu_res = opa >> shamt;
      EX_SHRA:  alu_res = $unsigned($signed(opa) >>> shamt);
      EX_LOADC: alu_res = {opa[DATA_W-1:CONST_W], constant};
      EX_MUL:   alu_res = '0;
      EX_LOAD:  alu_wb  = WB_MEMORY;
      default:  alu_wb  = WB_NONE;
    endcase
  end

  always_comb begin
    mem_read  = accept & (op == EX_LOAD);
    mem_write = accept & (op == EX_STORE);
    address   = (mem_read | mem_write) ? opa[ADDR_W-1:0] : '0;
    data_out  = mem_write ? opb : '0;
  end

  // A finishing MUL and a new accept are mutually exclusive (in_ready is low in ST_MUL).
  always_comb begin
    dep_valid       = single_reg | mul_done;
    dep_result      = '0;
    dep_destination = '0;
    if (mul_done) begin
      dep_result      = mul_product;
      dep_destination = mul_dst_q;
    end else if (single_reg) begin
      dep_result      = alu_res;
      dep_destination = dst;
    end
  end

  always_comb begin
    state_d       = state_q;
    halt_d        = halt_q | (accept & (op == EX_HALT));
    mul_dst_d     = mul_start ? dst : mul_dst_q;
    out_valid_d   = out_valid_q;
    result_d      = result_q;
    destination_d = destination_q;
    writeback_d   = writeback_q;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MUL;
      ST_MUL:  if (mul_done)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (load_out) begin
      out_valid_d   = 1'b1;
      result_d      = mul_done ? mul_product : alu_res;
      destination_d = mul_done ? mul_dst_q : dst;
      writeback_d   = mul_done ? WB_REGISTER : alu_wb;
    end else if (out_valid_q & out_ready) begin
      out_valid_d   = 1'b0;
      result_d      = '0;
      destination_d = '0;
      writeback_d   = WB_NONE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      result_q      <= '0;
      destination_q <= '0;
      writeback_q   <= WB_NONE;
      out_valid_q   <= 1'b0;
      halt_q        <= 1'b0;
      mul_dst_q     <= '0;
    end else begin
      state_q       <= state_d;
      result_q      <= result_d;
      destination_q <= destination_d;
      writeback_q   <= writeback_d;
      out_valid_q   <= out_valid_d;
      halt_q        <= halt_d;
      mul_dst_q     <= mul_dst_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign destination = destination_q;
  assign writeback   = writeback_q;
  assign halt        = halt_q;

`ifdef EXEC_FLAGS_EN
  logic [3:0]      flags_q, flags_d;
  logic [DATA_W:0] ext_sum;
  logic            alu_c, alu_v;

  // C is carry-out for ADD and borrow for SUB.
  always_comb begin
    ext_sum = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    if (op == EX_ADD) begin
      ext_sum = {1'b0, opa} + {1'b0, opb};
      alu_c   = ext_sum[DATA_W];
      alu_v   = (opa[DATA_W-1] == opb[DATA_W-1]) & (ext_sum[DATA_W-1] != opa[DATA_W-1]);
    end else if (op == EX_SUB) begin
      ext_sum = {1'b0, opa} - {1'b0, opb};
      alu_c   = ext_sum[DATA_W];
      alu_v   = (opa[DATA_W-1] != opb[DATA_W-1]) & (ext_sum[DATA_W-1] != opa[DATA_W-1]);
    end
  end

  always_comb begin
    flags_d = flags_q;
    if (load_out & (writeback_d == WB_REGISTER)) begin
      flags_d = {result_d == '0, result_d[DATA_W-1],
                 alu_c & !mul_done, alu_v & !mul_done};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign flags = flags_q;
`endif

endmodule

// File: tb/tb_multicycle_execute_unit.sv
// Directed scoreboard bench for multicycle_execute_unit (default build, no flags port).
module tb_multicycle_execute_unit;
  import multicycle_execute_unit_pkg::*;

  logic        clock, reset, in_valid, in_ready;
  logic [3:0]  op;
  logic [2:0]  dst;
  logic [15:0] opa, opb;
  logic [3:0]  shamt;
  logic [7:0]  constant;
  logic        dep_valid;
  logic [15:0] dep_result;
  logic [2:0]  dep_destination;
  logic        mem_read, mem_write;
  logic [9:0]  address;
  logic [15:0] data_out;
  logic        out_valid, out_ready;
  logic [15:0] result;
  logic [2:0]  destination;
  logic [1:0]  writeback;
  logic        halt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  dst;
    logic [1:0]  wb;
    logic        chk_res;
  } exp_t;
  exp_t sbq[$];

  multicycle_execute_unit dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .dst(dst), .opa(opa), .opb(opb), .shamt(shamt), .constant(constant),
    .dep_valid(dep_valid), .dep_result(dep_result), .dep_destination(dep_destination),
    .mem_read(mem_read), .mem_write(mem_write), .address(address), .data_out(data_out),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .destination(destination), .writeback(writeback), .halt(halt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one op, waits (bounded) for acceptance, checks the accept-cycle comb outputs.
  task automatic issue(input string tag, input logic [3:0] o, input logic [2:0] d,
                       input logic [15:0] a, input logic [15:0] b, input logic [3:0] sh,
                       input logic [7:0] c, input logic exp_dep, input logic [15:0] exp_res,
                       input logic [1:0] exp_wb, input logic exp_rd, input logic exp_wr,
                       input logic [9:0] exp_addr, input logic [15:0] exp_dout,
                       input logic push, input logic chk_res);
    int n;
    exp_t e;
    op = o; dst = d; opa = a; opb = b; shamt = sh; constant = c; in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clock); #1; n++;
    end
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_dep_valid"}, dep_valid, exp_dep);
    chk({tag, "_dep_result"}, dep_result, exp_dep ? exp_res : 16'h0);
    chk({tag, "_dep_dest"}, dep_destination, exp_dep ? d : 3'h0);
    chk({tag, "_mem_read"}, mem_read, exp_rd);
    chk({tag, "_mem_write"}, mem_write, exp_wr);
    chk({tag, "_address"}, address, exp_addr);
    chk({tag, "_data_out"}, data_out, exp_dout);
    @(posedge clock);
    if (push) begin
      e.res = exp_res; e.dst = d; e.wb = exp_wb; e.chk_res = chk_res;
      sbq.push_back(e);
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag);
    int n;
    exp_t e;
    #1;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clock); #1; n++;
    end
    chk({tag, "_out_valid"}, out_valid, 1);
    checks++;
    assert (sbq.size() != 0) else begin
      failures++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      if (e.chk_res) begin
        chk({tag, "_result"}, result, e.res);
        chk({tag, "_destination"}, destination, e.dst);
      end
      chk({tag, "_writeback"}, writeback, e.wb);
    end
  endtask

  // Counts stalled cycles after a MUL accept and captures the forwarded value.
  task automatic mul_wait(input string tag, input logic [15:0] exp_p, input logic [2:0] d);
    int n, dep_cnt, dep_idx;
    logic [15:0] dep_r;
    logic [2:0]  dep_d;
    n = 0; dep_cnt = 0; dep_idx = -1; dep_r = '0; dep_d = '0;
    #1;
    while (!in_ready && n < 40) begin
      if (dep_valid) begin
        dep_cnt++; dep_idx = n; dep_r = dep_result; dep_d = dep_destination;
      end
      n++;
      @(negedge clock); #1;
    end
    chk({tag, "_busy_cycles"}, n, 16);
    chk({tag, "_dep_count"}, dep_cnt, 1);
    chk({tag, "_dep_cycle"}, dep_idx, 15);
    chk({tag, "_dep_result"}, dep_r, exp_p);
    chk({tag, "_dep_dest"}, dep_d, d);
  endtask

  initial begin
    int rises, rdy_seen;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; dst = '0; opa = '0; opb = '0; shamt = '0; constant = '0;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_destination", destination, 0);
    chk("rst_writeback", writeback, WB_NONE);
    chk("rst_halt", halt, 0);
    chk("rst_dep_valid", dep_valid, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    issue("add", EX_ADD, 3'd2, 16'h7FFF, 16'h0001, 4'd0, 8'h00, 1, 16'h8000, WB_REGISTER,
          0, 0, 10'h0, 16'h0, 1, 1);
    check_out("add");

    issue("mul1", EX_MUL, 3'd5, 16'd123, 16'd45, 4'd0, 8'h00, 0, 16'd5535, WB_REGISTER,
          0, 0, 10'h0, 16'h0, 1, 1);
    mul_wait("mul1", 16'd5535, 3'd5);
    check_out("mul1");
    issue("mul2", EX_MUL, 3'd6, 16'd300, 16'd300, 4'd0, 8'h00, 0, 16'h5F90, WB_REGISTER,
          0, 0, 10'h0, 16'h0, 1, 1);
    mul_wait("mul2", 16'h5F90, 3'd6);
    check_out("mul2");

    @(negedge clock);
    out_ready = 1'b0;
    issue("stall_add", EX_ADD, 3'd1, 16'd3, 16'd4, 4'd0, 8'h00, 1, 16'd7, WB_REGISTER,
          0, 0, 10'h0, 16'h0, 1, 1);
    check_out("stall_add");
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      chk("stall_out_valid", out_valid, 1);
      chk("stall_result", result, 16'd7);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    issue("sub_release", EX_SUB, 3'd3, 16'd5, 16'd7, 4'd0, 8'h00, 1, 16'hFFFE, WB_REGISTER,
          0, 0, 10'h0, 16'h0, 1, 1);
    check_out("sub_release");

    issue("store", EX_STORE, 3'd0, 16'h0123, 16'hBEEF, 4'd0, 8'h00, 0, 16'h0, WB_NONE,
          0, 1, 10'h123, 16'hBEEF, 1, 0);
    #1;
    chk("store_strobe_drop", mem_write, 0);
    chk("store_addr_drop", address, 0);
    chk("store_data_drop", data_out, 0);
    check_out("store");
    issue("load", EX_LOAD, 3'd4, 16'h3FF5, 16'h1111, 4'd0, 8'h00, 0, 16'h0, WB_MEMORY,
          1, 0, 10'h3F5, 16'h0, 1, 1);
    check_out("load");

    issue("shra", EX_SHRA, 3'd1, 16'h8000, 16'h0, 4'd15, 8'h00, 1, 16'hFFFF, WB_REGISTER,
          0, 0, 10'h0, 16'h0, 1, 1);
    check_out("shra");
    issue("shr", EX_SHR, 3'd2, 16'h8000, 16'h0, 4'd15, 8'h00, 1, 16'h0001, WB_REGISTER,
          0, 0, 10'h0, 16'h0, 1, 1);
    check_out("shr");
    issue("shl0", EX_SHL, 3'd3, 16'hA5C3, 16'h0, 4'd0, 8'h00, 1, 16'hA5C3, WB_REGISTER,
          0, 0, 10'h0, 16'h0, 1, 1);
    check_out("shl0");
    issue("loadc", EX_LOADC, 3'd7, 16'hAB00, 16'h0, 4'd0, 8'h5C, 1, 16'hAB5C, WB_REGISTER,
          0, 0, 10'h0, 16'h0, 1, 1);
    check_out("loadc");
    issue("xnor", EX_XNOR, 3'd4, 16'h00FF, 16'h0F0F, 4'd0, 8'h00, 1, 16'hF00F, WB_REGISTER,
          0, 0, 10'h0, 16'h0, 1, 1);
    check_out("xnor");

    issue("mul_rst", EX_MUL, 3'd2, 16'd10, 16'd10, 4'd0, 8'h00, 0, 16'd100, WB_REGISTER,
          0, 0, 10'h0, 16'h0, 0, 1);
    repeat (4) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_result", result, 0);
    chk("mrst_writeback", writeback, WB_NONE);
    chk("mrst_dep_valid", dep_valid, 0);
    chk("mrst_halt", halt, 0);
    @(negedge clock);
    reset = 1'b1;
    rises = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock); #1;
      if (out_valid) rises++;
    end
    chk("mrst_no_output", rises, 0);
    chk("mrst_in_ready", in_ready, 1);

    issue("halt", EX_HALT, 3'd0, 16'h0, 16'h0, 4'd0, 8'h00, 0, 16'h0, WB_NONE,
          0, 0, 10'h0, 16'h0, 1, 0);
    check_out("halt");
    chk("halt_set", halt, 1);
    chk("halt_in_ready", in_ready, 0);
    op = EX_ADD; opa = 16'd1; opb = 16'd1; dst = 3'd1; in_valid = 1'b1;
    rdy_seen = 0; rises = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); #1;
      if (in_ready) rdy_seen++;
      if (out_valid) rises++;
    end
    in_valid = 1'b0;
    chk("halt_blocks_ready", rdy_seen, 0);
    chk("halt_blocks_output", rises, 0);
    chk("halt_sticky", halt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
